// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Segment vectors are ordered a=bit0 .. g=bit6, active-high.
package seg7_pkg;

  localparam int unsigned SegA = 0;
  localparam int unsigned SegB = 1;
  localparam int unsigned SegC = 2;
  localparam int unsigned SegD = 3;
  localparam int unsigned SegE = 4;
  localparam int unsigned SegF = 5;
  localparam int unsigned SegG = 6;

  localparam logic [6:0] Glyph0 = 7'h3F;
  localparam logic [6:0] Glyph1 = 7'h06;
  localparam logic [6:0] Glyph2 = 7'h5B;
  localparam logic [6:0] Glyph3 = 7'h4F;
  localparam logic [6:0] Glyph4 = 7'h66;
  localparam logic [6:0] Glyph5 = 7'h6D;
  localparam logic [6:0] Glyph6 = 7'h7D;
  localparam logic [6:0] Glyph7 = 7'h07;
  localparam logic [6:0] Glyph8 = 7'h7F;
  localparam logic [6:0] Glyph9 = 7'h6F;
  localparam logic [6:0] GlyphA = 7'h77;
  localparam logic [6:0] GlyphB = 7'h7C;
  localparam logic [6:0] GlyphC = 7'h39;
  localparam logic [6:0] GlyphD = 7'h5E;
  localparam logic [6:0] GlyphE = 7'h79;
  localparam logic [6:0] GlyphF = 7'h71;

  typedef enum logic {
    StBlank,
    StOn
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to 7-segment glyph decoder (0-9, A b C d E F).
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = '0;
    unique case (bcd_i)
      4'h0: seg_o = Glyph0;
      4'h1: seg_o = Glyph1;
      4'h2: seg_o = Glyph2;
      4'h3: seg_o = Glyph3;
      4'h4: seg_o = Glyph4;
      4'h5: seg_o = Glyph5;
      4'h6: seg_o = Glyph6;
      4'h7: seg_o = Glyph7;
      4'h8: seg_o = Glyph8;
      4'h9: seg_o = Glyph9;
      4'hA: seg_o = GlyphA;
      4'hB: seg_o = GlyphB;
      4'hC: seg_o = GlyphC;
      4'hD: seg_o = GlyphD;
      4'hE: seg_o = GlyphE;
      4'hF: seg_o = GlyphF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scan controller with tear-free frame-boundary updates.
// Optional leading-zero suppression when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned DWELL_CYC = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [4*N_DIGITS-1:0] upd_bcd,
  input  logic [N_DIGITS-1:0]   upd_dp,
  output logic [6:0]            Segments,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic                  frame_start
);

  localparam int unsigned MaxCyc = (BLANK_CYC > DWELL_CYC) ? BLANK_CYC : DWELL_CYC;
  localparam int unsigned TimerW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned IdxW   = $clog2(N_DIGITS);

  localparam logic [TimerW-1:0] BlankLast = TimerW'(BLANK_CYC - 1);
  localparam logic [TimerW-1:0] DwellLast = TimerW'(DWELL_CYC - 1);
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(N_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [4*N_DIGITS-1:0] active_bcd_q, active_bcd_d;
  logic [N_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [4*N_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;
  logic                  frame_start_q, frame_start_d;

  logic                  accept;
  logic                  boundary;
  logic [3:0]            cur_bcd;
  logic [6:0]            cur_seg;
  logic [N_DIGITS-1:0]   lz_mask;

  assign accept = upd_valid & ~pend_full_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    active_bcd_d  = active_bcd_q;
    active_dp_d   = active_dp_q;
    pend_bcd_d    = pend_bcd_q;
    pend_dp_d     = pend_dp_q;
    pend_full_d   = pend_full_q;
    boundary      = 1'b0;

    if (!en) begin
      state_d = StBlank;
      idx_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StBlank: begin
          if (timer_q == BlankLast) begin
            state_d = StOn;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StOn: begin
          if (timer_q == DwellLast) begin
            state_d = StBlank;
            timer_d = '0;
            if (idx_q == LastIdx) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
      endcase
    end

    frame_start_d = boundary;

    // Accept only happens with pending empty, so it never collides with the transfer below.
    if (boundary && pend_full_q) begin
      active_bcd_d = pend_bcd_q;
      active_dp_d  = pend_dp_q;
      pend_full_d  = 1'b0;
    end
    if (accept) begin
      pend_bcd_d  = upd_bcd;
      pend_dp_d   = upd_dp;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StBlank;
      idx_q         <= '0;
      timer_q       <= '0;
      active_bcd_q  <= '0;
      active_dp_q   <= '0;
      pend_bcd_q    <= '0;
      pend_dp_q     <= '0;
      pend_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      active_bcd_q  <= active_bcd_d;
      active_dp_q   <= active_dp_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_dp_q     <= pend_dp_d;
      pend_full_q   <= pend_full_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cur_bcd = active_bcd_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_bcd),
    .seg_o (cur_seg)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic all_zero;
  // Walk from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (active_bcd_q[4*k +: 4] == 4'h0);
      lz_mask[k] = all_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    dig_sel  = '1;
    Segments = '0;
    dp       = 1'b0;
    if (state_q == StOn) begin
      dig_sel[idx_q] = 1'b0;
      Segments       = lz_mask[idx_q] ? 7'h00 : cur_seg;
      dp             = active_dp_q[idx_q];
    end
  end

  assign upd_ready   = ~pend_full_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl (N=4, DWELL=8, BLANK=2, 40-cycle frame).
module tb_seg7_scan_ctrl;

  localparam int Frame = 40;

  localparam logic [6:0] GlyphTbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_bcd;
  logic [3:0]  upd_dp;
  logic [6:0]  Segments;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        frame_start;

  seg7_scan_ctrl #(
    .N_DIGITS  (4),
    .DWELL_CYC (8),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_bcd     (upd_bcd),
    .upd_dp      (upd_dp),
    .Segments    (Segments),
    .dp          (dp),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int t;  // cycles since the scan last started from BLANK of digit 0

  // Reference model of the displayed and pending data.
  logic [15:0] m_act_bcd;
  logic [3:0]  m_act_dp;
  logic [15:0] m_pend_bcd;
  logic [3:0]  m_pend_dp;
  logic        m_full;
  logic        m_fs;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic check_scan();
    int         pos;
    int         d;
    int         w;
    logic [3:0] e_sel;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] nib;
    logic       sup;
    pos   = t % Frame;
    d     = pos / 10;
    w     = pos % 10;
    e_sel = 4'hF;
    e_seg = 7'h00;
    e_dp  = 1'b0;
    if (w >= 2) begin
      e_sel[d] = 1'b0;
      nib      = m_act_bcd[4*d +: 4];
      sup      = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
      if (d >= 1 && (m_act_bcd >> (4 * d)) == 16'h0) sup = 1'b1;
`endif
      e_seg = sup ? 7'h00 : GlyphTbl[nib];
      e_dp  = m_act_dp[d];
    end
    check_val("dig_sel", 32'(dig_sel), 32'(e_sel));
    check_val("segments", 32'(Segments), 32'(e_seg));
    check_val("dp", 32'(dp), 32'(e_dp));
    check_val("frame_start", 32'(frame_start), 32'(m_fs));
    check_val("upd_ready", 32'(upd_ready), 32'(!m_full));
  endtask

  task automatic tick();
    logic        rst_s;
    logic        en_s;
    logic        acc;
    logic [15:0] in_bcd;
    logic [3:0]  in_dp;
    rst_s  = rst_n;
    en_s   = en;
    acc    = upd_valid && !m_full;
    in_bcd = upd_bcd;
    in_dp  = upd_dp;
    @(posedge clk);
    #1;
    m_fs = 1'b0;
    if (!rst_s) begin
      t         = 0;
      m_full    = 1'b0;
      m_act_bcd = '0;
      m_act_dp  = '0;
    end else begin
      if (!en_s) begin
        t = 0;
      end else begin
        t++;
        if (t % Frame == 0) begin
          m_fs = 1'b1;
          if (m_full) begin
            m_act_bcd = m_pend_bcd;
            m_act_dp  = m_pend_dp;
            m_full    = 1'b0;
          end
        end
      end
      if (acc) begin
        m_pend_bcd = in_bcd;
        m_pend_dp  = in_dp;
        m_full     = 1'b1;
      end
    end
    check_scan();
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while (t != target && guard < 1000) begin
      tick();
      guard++;
    end
    check_val("run_until_reached", 32'(t), 32'(target));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    t         = 0;
    m_act_bcd = '0;
    m_act_dp  = '0;
    m_pend_bcd = '0;
    m_pend_dp = '0;
    m_full    = 1'b0;
    m_fs      = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b1;
    upd_valid = 1'b0;
    upd_bcd   = '0;
    upd_dp    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check_val("rst_dig_sel", 32'(dig_sel), 32'h0000000F);
    check_val("rst_segments", 32'(Segments), 32'h0);
    check_val("rst_dp", 32'(dp), 32'h0);
    check_val("rst_upd_ready", 32'(upd_ready), 32'h1);
    check_val("rst_frame_start", 32'(frame_start), 32'h0);

    // Scan order and first frame boundary
    run_until(2);
    check_val("first_on_dig0", 32'(dig_sel), 32'h0000000E);
    run_until(12);
    check_val("first_on_dig1", 32'(dig_sel), 32'h0000000D);
    run_until(40);
    check_val("frame_pulse_40", 32'(frame_start), 32'h1);
    tick();
    check_val("frame_pulse_one_cycle", 32'(frame_start), 32'h0);

    // Mid-frame update, applied at the next boundary
    run_until(45);
    upd_valid = 1'b1;
    upd_bcd   = 16'h1234;
    upd_dp    = 4'b0100;
    tick();
    upd_valid = 1'b0;
    check_val("ready_drops", 32'(upd_ready), 32'h0);
    run_until(79);
    check_val("old_data_kept", 32'(Segments), 32'h3F);
    run_until(80);
    check_val("ready_back", 32'(upd_ready), 32'h1);
    run_until(82);
    check_val("d0_shows_4", 32'(Segments), 32'h66);
    run_until(102);
    check_val("d2_shows_2", 32'(Segments), 32'h5B);
    check_val("d2_dp", 32'(dp), 32'h1);

    // Offer exactly on the boundary cycle: no bypass, one extra frame of latency
    run_until(119);
    upd_valid = 1'b1;
    upd_bcd   = 16'h0007;
    upd_dp    = 4'b0001;
    tick();
    upd_valid = 1'b0;
    check_val("boundary_accept_pending", 32'(upd_ready), 32'h0);
    run_until(122);
    check_val("boundary_no_bypass", 32'(Segments), 32'h66);
    run_until(162);
    check_val("d0_shows_7", 32'(Segments), 32'h07);
    check_val("d0_dp7", 32'(dp), 32'h1);
    run_until(172);
`ifdef SEG7_LZ_BLANK_EN
    check_val("d1_lz_blank", 32'(Segments), 32'h00);
`else
    check_val("d1_zero_shown", 32'(Segments), 32'h3F);
`endif
    run_until(192);
`ifdef SEG7_LZ_BLANK_EN
    check_val("d3_lz_blank", 32'(Segments), 32'h00);
`else
    check_val("d3_zero_shown", 32'(Segments), 32'h3F);
`endif

    // Enable drop during digit 2 ON; handshake keeps working
    run_until(224);
    en        = 1'b0;
    upd_valid = 1'b1;
    upd_bcd   = 16'h00C0;
    upd_dp    = 4'b0000;
    tick();
    upd_valid = 1'b0;
    check_val("en_off_blank", 32'(dig_sel), 32'h0000000F);
    check_val("en_off_accept", 32'(upd_ready), 32'h0);
    repeat (4) tick();
    check_val("en_off_no_frame", 32'(frame_start), 32'h0);
    en = 1'b1;
    tick();
    check_val("reen_blank", 32'(dig_sel), 32'h0000000F);
    tick();
    check_val("reen_dig0", 32'(dig_sel), 32'h0000000E);
    run_until(40);
    check_val("reen_frame_pulse", 32'(frame_start), 32'h1);
    run_until(52);
    check_val("d1_shows_c", 32'(Segments), 32'h39);

    // Reset with pending data held: pending must be discarded
    run_until(55);
    upd_valid = 1'b1;
    upd_bcd   = 16'h5555;
    upd_dp    = 4'b1111;
    tick();
    upd_valid = 1'b0;
    check_val("pend_full_before_rst", 32'(upd_ready), 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("rst2_ready", 32'(upd_ready), 32'h1);
    check_val("rst2_dig_sel", 32'(dig_sel), 32'h0000000F);
    run_until(2);
    check_val("rst2_active_cleared", 32'(Segments), 32'h3F);
    run_until(82);
    check_val("rst2_pending_gone", 32'(Segments), 32'h3F);
    check_val("rst2_dp_gone", 32'(dp), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
